multi_timer: RTL and testbench

Parametrised multi-channel programmable timer with a shared free-running divider, for the console's peripheral bus beside the interrupt controller. Each channel counts falling edges of a selectable divider tap or the previous channel's overflow. On overflow a channel reloads after a programmable delay, raises a sticky interrupt flag, and optionally stops itself (one-shot). All state advances only on `cpu_en` cycles.

---
 rtl/multi_timer_if.sv | 24 ++
 rtl/multi_timer.sv | 163 ++++++++++++++++
 tb/tb_multi_timer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_timer_if
//  Description : Peripheral bus bundle for multi_timer: register select,
//                write strobe and data, combinational read data and the
//                per-channel interrupt lines.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_timer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
);
  localparam int ADDR_W = $clog2(NUM_CH + 1) + 2;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic [DATA_W-1:0] rdata;
  logic [NUM_CH-1:0] timer_int;

  modport master (output addr, wdata, write, input rdata, timer_int);
  modport slave  (input addr, wdata, write, output rdata, timer_int);
endinterface
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_timer
//  Description : Multi-channel programmable timer. A shared free-running
//                divider feeds per-channel falling-edge tick detectors (or a
//                cascade from the previous channel's overflow). Overflow
//                reloads after RELOAD_DELAY enabled cycles and raises a
//                sticky pending flag; one-shot channels stop themselves.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 8,
  parameter int DIV_W        = 16,
  parameter int RELOAD_DELAY = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  input  wire logic     cpu_en,
  input  wire logic     stop,
  multi_timer_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_CH + 1) + 2;
  localparam int DLY_W  = $clog2(RELOAD_DELAY + 2);
  localparam int DIV_IW = $clog2(DIV_W);
  localparam logic [DLY_W-1:0] c_DLY = DLY_W'(RELOAD_DELAY);

  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_count  [NUM_CH];
  logic [DATA_W-1:0] r_reload [NUM_CH];
  logic [2:0]        r_tap    [NUM_CH];
  logic [DLY_W-1:0]  r_dly    [NUM_CH];
  logic [NUM_CH-1:0] r_en, r_os, r_ie, r_pend, r_hist;

  logic              w_wr, w_wr_div, w_carry;
  logic [NUM_CH-1:0] w_wr_cnt, w_wr_rld, w_wr_ctl, w_wr_sts;
  logic [NUM_CH-1:0] w_lvl, w_tick, w_ovf, w_rld;
  logic [DATA_W-1:0] w_rdata;

  assign w_wr          = cpu_en & bus.write;
  assign bus.rdata     = w_rdata;
  assign bus.timer_int = r_pend & r_ie;

  // Write decode, tick detection and overflow; the cascade carry ripples
  // from channel 0 upward so a chained overflow lands in the same cycle.
  always_comb begin
    w_wr_div = w_wr & (bus.addr == '0);
    w_wr_cnt = '0;
    w_wr_rld = '0;
    w_wr_ctl = '0;
    w_wr_sts = '0;
    w_lvl    = '0;
    w_tick   = '0;
    w_ovf    = '0;
    w_rld    = '0;
    w_carry  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_cnt[c] = w_wr & (bus.addr == ADDR_W'(4 * c + 4));
      w_wr_rld[c] = w_wr & (bus.addr == ADDR_W'(4 * c + 5));
      w_wr_ctl[c] = w_wr & (bus.addr == ADDR_W'(4 * c + 6));
      w_wr_sts[c] = w_wr & (bus.addr == ADDR_W'(4 * c + 7));
      if (r_tap[c] == 3'd7) begin
        // channel 0 sees a zero carry, so its cascade tap never ticks
        w_tick[c] = r_en[c] & w_carry;
      end else begin
        w_lvl[c]  = r_en[c] & r_div[DIV_IW'({r_tap[c], 1'b1}) + DIV_IW'(2)];
        w_tick[c] = r_hist[c] & ~w_lvl[c];
      end
      w_ovf[c] = w_tick[c] & (&r_count[c]);
      w_carry  = w_ovf[c];
      // a COUNT write anywhere in the delay window cancels the reload
      if (RELOAD_DELAY == 0) begin
        w_rld[c] = w_ovf[c] & ~w_wr_cnt[c];
      end else begin
        w_rld[c] = (r_dly[c] == c_DLY) & ~w_wr_cnt[c];
      end
    end
  end

  // Combinational register read; unmapped addresses return zero.
  always_comb begin
    w_rdata = '0;
    if (bus.addr == '0) begin
      w_rdata = r_div[DIV_W-1 -: DATA_W];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.addr[ADDR_W-1:2] == (ADDR_W-2)'(c + 1)) begin
        case (bus.addr[1:0])
          2'd0:    w_rdata = r_count[c];
          2'd1:    w_rdata = r_reload[c];
          2'd2:    w_rdata = {{(DATA_W-6){1'b0}}, r_ie[c], r_os[c], r_en[c], r_tap[c]};
          default: w_rdata = {{(DATA_W-1){1'b0}}, r_pend[c]};
        endcase
      end
    end
  end

  // Divider and per-channel state; everything advances only on cpu_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_en   <= '0;
      r_os   <= '0;
      r_ie   <= '0;
      r_pend <= '0;
      r_hist <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_count[c]  <= '0;
        r_reload[c] <= '0;
        r_tap[c]    <= '0;
        r_dly[c]    <= '0;
      end
    end else if (cpu_en) begin
      if (stop || w_wr_div) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c] <= w_lvl[c];

        if (w_wr_cnt[c]) begin
          r_count[c] <= bus.wdata;
        end else if (w_rld[c]) begin
          r_count[c] <= r_reload[c];
        end else if (w_tick[c]) begin
          r_count[c] <= r_count[c] + DATA_W'(1);
        end

        if (w_wr_rld[c]) begin
          r_reload[c] <= bus.wdata;
        end

        if (w_wr_ctl[c]) begin
          r_tap[c] <= bus.wdata[2:0];
          r_en[c]  <= bus.wdata[3];
          r_os[c]  <= bus.wdata[4];
          r_ie[c]  <= bus.wdata[5];
        end else if (w_ovf[c] && r_os[c]) begin
          r_en[c] <= 1'b0;
        end

        // setting wins over a simultaneous write-one-to-clear
        if (w_rld[c]) begin
          r_pend[c] <= 1'b1;
        end else if (w_wr_sts[c] && bus.wdata[0]) begin
          r_pend[c] <= 1'b0;
        end

        if (RELOAD_DELAY == 0 || w_wr_cnt[c]) begin
          r_dly[c] <= '0;
        end else if (w_ovf[c]) begin
          r_dly[c] <= DLY_W'(1);
        end else if (r_dly[c] == c_DLY) begin
          r_dly[c] <= '0;
        end else if (r_dly[c] != '0) begin
          r_dly[c] <= r_dly[c] + DLY_W'(1);
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_timer
//  Description : Self-checking bench for multi_timer. Two instances (reload
//                delay 4 and 0) share one stimulus stream and are compared
//                every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_timer;
  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DIVW  = 16;
  localparam int AW    = $clog2(NCH + 1) + 2;
  localparam int MAXC  = (1 << DW) - 1;
  localparam int NADDR = 1 << AW;

  logic clk = 1'b0;
  logic reset, cpu_en, stop;
  int   n_checks = 0;
  int   n_errors = 0;

  multi_timer_if #(.NUM_CH(NCH), .DATA_W(DW)) bus0 ();
  multi_timer_if #(.NUM_CH(NCH), .DATA_W(DW)) bus1 ();

  multi_timer #(.NUM_CH(NCH), .DATA_W(DW), .DIV_W(DIVW), .RELOAD_DELAY(4)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .stop(stop), .bus(bus0));
  multi_timer #(.NUM_CH(NCH), .DATA_W(DW), .DIV_W(DIVW), .RELOAD_DELAY(0)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .stop(stop), .bus(bus1));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int dly [2] = '{4, 0};
  int m_div;
  int m_cnt  [2][NCH];
  int m_rld  [2][NCH];
  int m_tap  [2][NCH];
  int m_left [2][NCH];   // enabled cycles until reload, -1 when idle
  bit m_en   [2][NCH];
  bit m_os   [2][NCH];
  bit m_ie   [2][NCH];
  bit m_pend [2][NCH];
  bit m_prev [2][NCH];

  logic [DW-1:0]  got_rd  [2];
  logic [NCH-1:0] got_int [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_div = 0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[k][c] = 0; m_rld[k][c] = 0; m_tap[k][c] = 0; m_left[k][c] = -1;
        m_en[k][c] = 0; m_os[k][c] = 0; m_ie[k][c] = 0; m_pend[k][c] = 0; m_prev[k][c] = 0;
      end
    end
  endfunction

  function automatic int exp_rd(int k, int a);
    int ch, r;
    if (a == 0) return (m_div >> (DIVW - DW)) & MAXC;
    ch = a / 4 - 1;
    r  = a % 4;
    if (ch < 0 || ch >= NCH) return 0;
    case (r)
      0: return m_cnt[k][ch];
      1: return m_rld[k][ch];
      2: return m_tap[k][ch] + 8 * int'(m_en[k][ch]) + 16 * int'(m_os[k][ch]) + 32 * int'(m_ie[k][ch]);
      default: return int'(m_pend[k][ch]);
    endcase
  endfunction

  function automatic int exp_irq(int k);
    int v = 0;
    for (int c = 0; c < NCH; c++) if (m_pend[k][c] && m_ie[k][c]) v |= (1 << c);
    return v;
  endfunction

  // One enabled cycle of instance k; every decision uses pre-cycle state.
  function automatic void model_step(int k, bit wr, int a, int d);
    bit carry, lvl, tick, ovf, load, wc;
    int base;
    carry = 0;
    for (int c = 0; c < NCH; c++) begin
      base = 4 * (c + 1);
      wc   = wr && (a == base);
      if (m_tap[k][c] == 7) begin
        lvl  = 0;
        tick = m_en[k][c] && carry;
      end else begin
        lvl  = m_en[k][c] && (((m_div >> (3 + 2 * m_tap[k][c])) & 1) != 0);
        tick = m_prev[k][c] && !lvl;
      end
      ovf   = tick && (m_cnt[k][c] == MAXC);
      carry = ovf;
      load  = !wc && ((dly[k] == 0) ? ovf : (m_left[k][c] == 0));
      m_prev[k][c] = lvl;
      if (wc)        m_cnt[k][c] = d & MAXC;
      else if (load) m_cnt[k][c] = m_rld[k][c];
      else if (tick) m_cnt[k][c] = (m_cnt[k][c] + 1) & MAXC;
      if (wr && a == base + 1) m_rld[k][c] = d & MAXC;
      if (wr && a == base + 2) begin
        m_tap[k][c] = d & 7;
        m_en[k][c]  = ((d >> 3) & 1) != 0;
        m_os[k][c]  = ((d >> 4) & 1) != 0;
        m_ie[k][c]  = ((d >> 5) & 1) != 0;
      end else if (ovf && m_os[k][c]) begin
        m_en[k][c] = 0;
      end
      if (load) m_pend[k][c] = 1;
      else if (wr && a == base + 3 && (d & 1) != 0) m_pend[k][c] = 0;
      if (wc)                    m_left[k][c] = -1;
      else if (ovf)              m_left[k][c] = (dly[k] > 0) ? dly[k] - 1 : -1;
      else if (m_left[k][c] >= 0) m_left[k][c] = m_left[k][c] - 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit en, input bit st, input bit wr, input int a, input int d, input bit rs);
    @(negedge clk);
    reset = rs; cpu_en = en; stop = st;
    bus0.write = wr; bus0.addr = AW'(a); bus0.wdata = DW'(d);
    bus1.write = wr; bus1.addr = AW'(a); bus1.wdata = DW'(d);
    #1;
    got_rd[0] = bus0.rdata; got_int[0] = bus0.timer_int;
    got_rd[1] = bus1.rdata; got_int[1] = bus1.timer_int;
    check_val("rdata_d4", got_rd[0], exp_rd(0, a));
    check_val("irq_d4",   got_int[0], exp_irq(0));
    check_val("rdata_d0", got_rd[1], exp_rd(1, a));
    check_val("irq_d0",   got_int[1], exp_irq(1));
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (en) begin
      model_step(0, wr, a, d);
      model_step(1, wr, a, d);
      m_div = (st || (wr && a == 0)) ? 0 : ((m_div + 1) & ((1 << DIVW) - 1));
    end
  endtask

  task automatic idle(input int n, input int a);
    repeat (n) cyc(1, 0, 0, a, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(1, 0, 1, a, d, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 1);
  endtask

  task automatic basic_setup();
    wr(4, 'hFE); wr(5, 'hF0); wr(6, 'h28);
  endtask

  task automatic wait_ovf0();
    for (int i = 0; i < 100 && m_left[0][0] < 0; i++) idle(1, 4);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NADDR; a++) begin
      cyc(0, 0, 0, a, 0, 0);
      check_val(tag, got_rd[0], 0);
      check_val(tag, got_rd[1], 0);
    end
    check_val({tag, "_irq"}, got_int[0], 0);
    check_val({tag, "_irq"}, got_int[1], 0);
  endtask

  initial begin
    bit en, st, w, rs;
    int a, d, t;

    reset = 1'b1; cpu_en = 1'b0; stop = 1'b0;
    bus0.write = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.write = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state
    check_all_zero("reset_rd");

    // basic reload and write-one-to-clear
    basic_setup();
    idle(60, 4);
    check_val("basic_irq_d4", got_int[0][0], 1);
    check_val("basic_irq_d0", got_int[1][0], 1);
    wr(7, 1);
    idle(1, 4);
    check_val("basic_clr_d4", got_int[0][0], 0);

    // COUNT write two cycles after overflow cancels the reload
    do_reset();
    basic_setup();
    wait_ovf0();
    idle(1, 4);
    wr(4, 'h55);
    idle(1, 4);
    check_val("cancel_cnt", got_rd[0], 'h55);
    idle(20, 7);
    check_val("cancel_pend", got_rd[0], 0);

    // cascade into a one-shot channel
    do_reset();
    wr(4, 'hFF); wr(5, 'hFF); wr(8, 'hFF); wr(10, 'h1F); wr(6, 'h08);
    idle(40, 10);
    check_val("casc_ctrl1_d4", got_rd[0], 'h17);
    check_val("casc_ctrl1_d0", got_rd[1], 'h17);
    idle(60, 8);
    check_val("casc_cnt1", got_rd[0], 0);
    idle(1, 11);
    check_val("casc_pend1", got_rd[0], 1);

    // DIV write while the tap bit is high ticks once, while low does not
    do_reset();
    wr(4, 'h10); wr(6, 'h08);
    for (int i = 0; i < 40 && ((m_div >> 3) & 1) == 0; i++) idle(1, 4);
    wr(0, 0);
    idle(3, 4);
    check_val("glitch_hi", got_rd[0], 'h11);
    wr(0, 0);
    idle(3, 4);
    check_val("glitch_lo", got_rd[0], 'h11);

    // cpu_en toggling every cycle
    do_reset();
    basic_setup();
    for (int i = 0; i < 200; i++) cyc(i % 2 == 0, 0, 0, 4, 0, 0);
    check_val("gate_irq", got_int[0][0], 1);

    // reset in the middle of the reload delay
    do_reset();
    basic_setup();
    wait_ovf0();
    idle(1, 4);
    do_reset();
    check_all_zero("mid_reset");

    // randomized traffic biased toward frequent overflows
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 31) == 0);
      w  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 999) == 0);
      a  = $urandom_range(0, NADDR - 1);
      d  = $urandom_range(0, 255);
      if (w && a >= 4 && a % 4 == 0) d = $urandom_range('hF8, 'hFF);
      if (w && a >= 4 && a % 4 == 2) begin
        t = $urandom_range(0, 2);
        d = (d & 'h38) | ((t == 2) ? 7 : t);
      end
      cyc(en, st, w, a, d, rs);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
